tennis_point_scorer: RTL
========================

# tennis_point_scorer

Point-level scoring stage that sits directly upstream of the LCD game/set controller. It synchronizes and debounces the two player pushbuttons and tracks tennis points (0, 15, 30, 40, deuce, advantage). It drives four 7-segment digits with the current point score and raises a held `p1win`/`p2win` flag when a game is won. The flag stays high until the controller acknowledges it on its command-ready strobe; the point score then restarts at 0–0.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 250000, cycles a raw button level must stay stable before it is accepted (5 ms at 50 MHz); minimum 2.

Ports:
- `clk`  input  1  system clock; all state is updated on the rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `p1`  input  1  raw player-1 pushbutton, active-low (pressed = 0), asynchronous to `clk`.
- `p2`  input  1  raw player-2 pushbutton, active-low, asynchronous.
- `ack`  input  1  controller command-ready strobe (`rdy_cmd`); a 0→1 transition acknowledges a pending win.
- `p1_point_0`  output  7  player-1 units digit, segments {g,f,e,d,c,b,a}, active-low.
- `p1_point_1`  output  7  player-1 tens digit, same encoding.
- `p2_point_0`, `p2_point_1`  output  7 each  player-2 units and tens digits.
- `p1win`  output  1  player 1 has won the current game; held until acknowledged.
- `p2win`  output  1  player 2 has won the current game; held until acknowledged.

## Operation
**Input conditioning, per button**
- Two-flop synchronizer feeds a stability counter.
- The accepted level changes only after `DEBOUNCE_CYCLES` consecutive equal synchronized samples.
- An accepted 1→0 transition produces a one-cycle `press` pulse.
- A held button scores exactly once; it must release through the debounced level before it can score again.

**Point FSM**
- States: `PTS` (counters a,b ∈ {0..3}), `DEUCE`, `ADV1`, `ADV2`, `WIN1`, `WIN2`.
- `PTS`, player-1 press:
  - a=3 and b<3 → `WIN1`.
  - a=2 and b=3 → `DEUCE`.
  - otherwise a+1.
- `PTS`, player-2 press: mirror of the player-1 rules.
- `DEUCE`: press1 → `ADV1`; press2 → `ADV2`.
- `ADV1`: press1 → `WIN1`; press2 → `DEUCE`.
- `ADV2`: press2 → `WIN2`; press1 → `DEUCE`.
- `WIN1`/`WIN2`: all presses ignored.
  - On an `ack` rising edge (registered edge detect on `ack`), go to `PTS` with a=b=0.
  - The matching win flag clears at that transition.
- Both `press` pulses in the same cycle: both discarded, no state change.
- An `ack` edge outside the WIN states is ignored.

**Display**
- Digit pairs: 0→"00", 15→"15", 30→"30", 40→"40". `DEUCE` shows "40"/"40".
- `ADVx`: the leader shows "Ad", the other player shows blank/blank.
- `WINx`: the winner shows "Ad", the loser keeps its last value.
- Segment codes (active-low, gfedcba):
  - 0 = 1000000, 1 = 1111001, 3 = 0110000, 4 = 0011001, 5 = 0010010.
  - A = 0001000, d = 0100001, blank = 1111111.
- All segment outputs are registered.

## Timing
- Reset (`rst`=0 at an edge):
  - FSM → `PTS` 0–0; debouncers → released; synchronizers → 1.
  - Outputs: all four digits show "0" (1000000); `p1win`=`p2win`=0.
  - Reset overrides everything, including a pending win and an in-progress debounce count.
- Latency: raw edge → `press` pulse = 2 sync cycles + `DEBOUNCE_CYCLES`. `press` → state update: 1 cycle. State → segments/win flag: 1 cycle, registered.
- Win handshake:
  - The flag rises one cycle after the winning press is registered.
  - It is held for as long as needed.
  - It falls one cycle after the first `ack` 0→1 seen while in `WINx`.
- `ack` is assumed synchronous to `clk`; the controller samples `p1win`/`p2win` on its own `rdy_cmd` edge, so the flags must be stable at least one cycle before the `ack` edge.

## Structure
- Package `tennis_pkg`:
  - FSM state enum.
  - Seven-segment constants (digits 0,1,3,4,5, A, d, blank).
  - Point-index-to-digit-pair lookup function.
- Sub-module `button_debouncer` (sync + counter + press pulse), instantiated once per player.

## Test plan
- Reset, then 4 player-1 presses → displays step 00/00, 15/00, 30/00, 40/00; `p1win`=1 after the 4th press; `ack` pulse → `p1win`=0 and display 00/00.
- 3 presses each, then p1, p2, p2, p2 → DEUCE 40/40, ADV1 Ad/blank, DEUCE, ADV2 blank/Ad, then `p2win`=1.
- A button bounce of 10 toggles at 100-cycle spacing (`DEBOUNCE_CYCLES`=1000) followed by a stable press → exactly one point.
- p1 and p2 accepted in the same cycle → score unchanged; a single button held for 10× `DEBOUNCE_CYCLES` → exactly one point.
- In `WIN1`, 3 further p2 presses → ignored, `p1win` stays 1; `ack` held high with no new edge → no clear.
- `rst`=0 while in `ADV1` with a debounce count in progress → next cycle shows 00/00, no win flag, and no spurious point after release.

Source files
------------

// File: rtl/tennis_pkg.sv
// rtl/tennis_pkg.sv - shared types and seven-segment constants for the tennis point scorer
//
// Purpose: point FSM state encoding, active-low gfedcba segment codes, and the
//          lookup that turns a point index (0..3) into a tens/units digit pair.
// Ports:   none (package).
package tennis_pkg;

  typedef enum logic [2:0] {
    PTS   = 3'd0,
    DEUCE = 3'd1,
    ADV1  = 3'd2,
    ADV2  = 3'd3,
    WIN1  = 3'd4,
    WIN2  = 3'd5
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Returns {tens, units}: 0 -> "00", 1 -> "15", 2 -> "30", 3 -> "40".
  function automatic logic [13:0] point_digits(input logic [1:0] idx);
    case (idx)
      2'd0:    return {SEG_0, SEG_0};
      2'd1:    return {SEG_1, SEG_5};
      2'd2:    return {SEG_3, SEG_0};
      default: return {SEG_4, SEG_0};
    endcase
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchronizer, stability counter and press pulse
//
// Purpose: conditions one raw active-low pushbutton into a one-cycle press pulse.
// Ports:   clk_i   system clock
//          rst_ni  synchronous active-low reset (level -> released)
//          btn_i   raw button, active-low, asynchronous
//          press_o one-cycle pulse on an accepted 1->0 transition
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      // cnt_q counts consecutive samples that disagree with the accepted level;
      // any agreeing sample restarts the count, so bounces never accumulate.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        press_q <= ~sync2_q;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/tennis_point_scorer.sv
// rtl/tennis_point_scorer.sv - tennis point FSM with debounced buttons and 7-segment outputs
//
// Purpose: tracks points 0/15/30/40/deuce/advantage, drives four registered
//          active-low digits and holds a win flag until acknowledged.
// Ports:   clk, rst (sync active-low), p1/p2 raw active-low buttons,
//          ack controller command-ready strobe (0->1 acknowledges a win),
//          p1_point_1/0, p2_point_1/0 tens/units digits, p1win/p2win flags.
module tennis_point_scorer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p1,
  input  logic       p2,
  input  logic       ack,
  output logic [6:0] p1_point_0,
  output logic [6:0] p1_point_1,
  output logic [6:0] p2_point_0,
  output logic [6:0] p2_point_1,
  output logic       p1win,
  output logic       p2win
);

  import tennis_pkg::*;

  logic       press1, press2;
  logic       ack_q;
  logic       ack_rise;
  state_e     state_q;
  logic [1:0] a_q, b_q;

  logic [6:0] p1_t_q, p1_u_q, p2_t_q, p2_u_q;
  logic       p1win_q, p2win_q;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p1 (
    .clk_i   (clk),
    .rst_ni  (rst),
    .btn_i   (p1),
    .press_o (press1)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p2 (
    .clk_i   (clk),
    .rst_ni  (rst),
    .btn_i   (p2),
    .press_o (press2)
  );

  assign ack_rise = ack & ~ack_q;

  // Simultaneous presses are treated as ambiguous and dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= PTS;
      a_q     <= 2'd0;
      b_q     <= 2'd0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= ack;
      case (state_q)
        PTS: begin
          if (press1 && !press2) begin
            if (a_q == 2'd3 && b_q != 2'd3) begin
              state_q <= WIN1;
            end else if (a_q == 2'd2 && b_q == 2'd3) begin
              state_q <= DEUCE;
              a_q     <= 2'd3;
            end else begin
              a_q <= a_q + 2'd1;
            end
          end else if (press2 && !press1) begin
            if (b_q == 2'd3 && a_q != 2'd3) begin
              state_q <= WIN2;
            end else if (b_q == 2'd2 && a_q == 2'd3) begin
              state_q <= DEUCE;
              b_q     <= 2'd3;
            end else begin
              b_q <= b_q + 2'd1;
            end
          end
        end
        DEUCE: begin
          if (press1 && !press2)      state_q <= ADV1;
          else if (press2 && !press1) state_q <= ADV2;
        end
        ADV1: begin
          if (press1 && !press2)      state_q <= WIN1;
          else if (press2 && !press1) state_q <= DEUCE;
        end
        ADV2: begin
          if (press2 && !press1)      state_q <= WIN2;
          else if (press1 && !press2) state_q <= DEUCE;
        end
        WIN1, WIN2: begin
          if (ack_rise) begin
            state_q <= PTS;
            a_q     <= 2'd0;
            b_q     <= 2'd0;
          end
        end
        default: state_q <= PTS;
      endcase
    end
  end

  // Display and flags are one register stage behind the state; in a WIN state
  // the loser's digits are simply not reloaded so they keep what was shown.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p1_t_q  <= SEG_0;
      p1_u_q  <= SEG_0;
      p2_t_q  <= SEG_0;
      p2_u_q  <= SEG_0;
      p1win_q <= 1'b0;
      p2win_q <= 1'b0;
    end else begin
      p1win_q <= (state_q == WIN1);
      p2win_q <= (state_q == WIN2);
      case (state_q)
        PTS: begin
          {p1_t_q, p1_u_q} <= point_digits(a_q);
          {p2_t_q, p2_u_q} <= point_digits(b_q);
        end
        DEUCE: begin
          {p1_t_q, p1_u_q} <= {SEG_4, SEG_0};
          {p2_t_q, p2_u_q} <= {SEG_4, SEG_0};
        end
        ADV1: begin
          {p1_t_q, p1_u_q} <= {SEG_A, SEG_D};
          {p2_t_q, p2_u_q} <= {SEG_BLANK, SEG_BLANK};
        end
        ADV2: begin
          {p1_t_q, p1_u_q} <= {SEG_BLANK, SEG_BLANK};
          {p2_t_q, p2_u_q} <= {SEG_A, SEG_D};
        end
        WIN1:    {p1_t_q, p1_u_q} <= {SEG_A, SEG_D};
        WIN2:    {p2_t_q, p2_u_q} <= {SEG_A, SEG_D};
        default: begin
          {p1_t_q, p1_u_q} <= {SEG_0, SEG_0};
          {p2_t_q, p2_u_q} <= {SEG_0, SEG_0};
        end
      endcase
    end
  end

  assign p1_point_1 = p1_t_q;
  assign p1_point_0 = p1_u_q;
  assign p2_point_1 = p2_t_q;
  assign p2_point_0 = p2_u_q;
  assign p1win      = p1win_q;
  assign p2win      = p2win_q;

endmodule
